// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: controller states and reduction-mode encodings.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        BIN,
        SHIFT,
        DONE
    } state_e;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One reduction step of the GCD datapath, either subtractive (Euclid) or binary (Stein).
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic             k_inc,
    output logic             equal
);

    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        diff_ab = a - b;
        diff_ba = b - a;
        a_next  = a;
        b_next  = b;
        k_inc   = 1'b0;
        equal   = (a == b);

        if (!equal) begin
            if (mode == MODE_SUB) begin
                if (a > b) begin
                    a_next = diff_ab;
                end else begin
                    b_next = diff_ba;
                end
            end else if (!a[0] && !b[0]) begin
                a_next = a >> 1;
                b_next = b >> 1;
                k_inc  = 1'b1;
            end else if (!a[0]) begin
                a_next = a >> 1;
            end else if (!b[0]) begin
                b_next = b >> 1;
            end else if (a > b) begin
                // Difference of two odd numbers is even, so halving it is exact.
                a_next = diff_ab >> 1;
            end else begin
                b_next = diff_ba >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: parallel operand load and result return over valid/ready, selectable Euclid/Stein reduction.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ITER_W  = WIDTH,
    parameter int SHIFT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  gcd_out,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              zero_in
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                mode_q, mode_d;
    logic [SHIFT_W-1:0]  k_q, k_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [WIDTH-1:0]    gcd_q, gcd_d;
    logic                zero_q, zero_d;

    logic [WIDTH-1:0]    step_a;
    logic [WIDTH-1:0]    step_b;
    logic                step_k_inc;
    logic                step_equal;
    logic [ITER_W-1:0]   iter_inc;

    gcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .mode   (mode_q),
        .a_next (step_a),
        .b_next (step_b),
        .k_inc  (step_k_inc),
        .equal  (step_equal)
    );

    assign iter_inc = (&iter_q) ? iter_q : iter_q + ITER_W'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        k_d     = k_q;
        iter_d  = iter_q;
        gcd_d   = gcd_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = a_in;
                    b_d    = b_in;
                    mode_d = mode;
                    iter_d = '0;
                    k_d    = '0;
                    if (a_in == '0 || b_in == '0) begin
                        gcd_d   = a_in | b_in;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = (mode == MODE_BIN) ? BIN : SUB;
                    end
                end
            end
            SUB: begin
                if (step_equal) begin
                    gcd_d   = a_q;
                    state_d = DONE;
                end else begin
                    a_d    = step_a;
                    b_d    = step_b;
                    iter_d = iter_inc;
                end
            end
            BIN: begin
                if (step_equal) begin
                    state_d = SHIFT;
                end else begin
                    a_d    = step_a;
                    b_d    = step_b;
                    k_d    = k_q + SHIFT_W'(step_k_inc);
                    iter_d = iter_inc;
                end
            end
            SHIFT: begin
                gcd_d   = a_q << k_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_SUB;
            k_q     <= '0;
            iter_q  <= '0;
            gcd_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            iter_q  <= iter_d;
            gcd_q   <= gcd_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign gcd_out   = gcd_q;
    assign iter_cnt  = iter_q;
    assign zero_in   = zero_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Randomised scoreboard bench for gcd_engine (16-bit) plus directed checks on an 8-bit instance.
module tb_gcd_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        in_valid, in_ready, mode, out_valid, out_ready, zero_in;
    logic [15:0] a_in, b_in, gcd_out, iter_cnt;
    logic        or_man, or_rnd, rand_mode;
    assign out_ready = rand_mode ? or_rnd : or_man;

    // 8-bit instance
    logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8, zero_in8;
    logic [7:0]  a_in8, b_in8, gcd_out8, iter_cnt8;

    gcd_engine #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .gcd_out(gcd_out), .iter_cnt(iter_cnt), .zero_in(zero_in)
    );

    gcd_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .a_in(a_in8), .b_in(b_in8), .mode(mode8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .gcd_out(gcd_out8), .iter_cnt(iter_cnt8), .zero_in(zero_in8)
    );

    typedef struct {
        int unsigned gcd;
        int unsigned iter;
        bit          zero;
        int unsigned lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Repeated subtraction performs (sum of Euclid quotients) subtractions, minus the last one that would reach zero.
    function automatic int unsigned ref_sub_iters(input int unsigned a, input int unsigned b);
        int unsigned t, sum;
        sum = 0;
        while (b != 0) begin
            sum += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return sum - 1;
    endfunction

    function automatic int unsigned ref_bin_iters(input int unsigned a, input int unsigned b);
        int unsigned n;
        n = 0;
        while (a != b) begin
            if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
            else if (a % 2 == 0) a = a / 2;
            else if (b % 2 == 0) b = b / 2;
            else if (a > b) a = (a - b) / 2;
            else b = (b - a) / 2;
            n++;
        end
        return n;
    endfunction

    function automatic exp_t make_exp(input int unsigned a, input int unsigned b, input bit m,
                                      input int unsigned iter_w);
        exp_t e;
        int unsigned steps, sat;
        sat = (1 << iter_w) - 1;
        e.zero = (a == 0 || b == 0);
        if (e.zero) begin
            e.gcd  = a | b;
            e.iter = 0;
            e.lat  = 1;
        end else begin
            e.gcd  = ref_gcd(a, b);
            steps  = m ? ref_bin_iters(a, b) : ref_sub_iters(a, b);
            e.iter = (steps > sat) ? sat : steps;
            e.lat  = steps + (m ? 3 : 2);
        end
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input int unsigned a, input int unsigned b, input bit m);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a_in     = 16'(a);
        b_in     = 16'(b);
        mode     = m;
        @(negedge clk);
        while (!in_ready) begin
            guard++;
            if (guard > 5000) begin
                check("send_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_q.push_back(make_exp(a, b, m, 16));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
        mode     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (exp_q.size() != 0 || out_valid) begin
            guard++;
            if (guard > 5000) begin
                check("drain_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit          armed = 0, shown = 0;
    int unsigned lat = 0;
    exp_t        mon_e;
    logic [15:0] h_gcd, h_iter;
    logic        h_zero;

    always @(negedge clk) begin
        if (rst) begin
            armed = 0;
            shown = 0;
            lat   = 0;
        end else begin
            if (armed) lat++;
            if (out_valid && !shown) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("gcd_out", gcd_out, mon_e.gcd);
                    check("iter_cnt", iter_cnt, mon_e.iter);
                    check("zero_in", zero_in, mon_e.zero);
                    check("latency", armed ? lat : 0, mon_e.lat);
                end
                shown  = 1;
                armed  = 0;
                h_gcd  = gcd_out;
                h_iter = iter_cnt;
                h_zero = zero_in;
            end else if (out_valid) begin
                check("hold_gcd_out", gcd_out, h_gcd);
                check("hold_iter_cnt", iter_cnt, h_iter);
                check("hold_zero_in", zero_in, h_zero);
                check("in_ready_while_done", in_ready, 0);
            end
            if (out_valid && out_ready) shown = 0;
            if (in_valid && in_ready) begin
                armed = 1;
                lat   = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1 or_rnd = 1'($urandom_range(0, 1));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        exp_t        e8;
        int unsigned ra, rb;
        bit          rm;

        rst = 1'b1;
        in_valid = 1'b0; a_in = '0; b_in = '0; mode = 1'b0;
        or_man = 1'b1; rand_mode = 1'b0;
        in_valid8 = 1'b0; a_in8 = '0; b_in8 = '0; mode8 = 1'b0; out_ready8 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_gcd_out", gcd_out, 0);
        check("rst_iter_cnt", iter_cnt, 0);
        check("rst_zero_in", zero_in, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed cases through the scoreboard
        send(143, 78, 0);
        send(48, 18, 1);
        send(0, 35, 0);
        send(0, 0, 1);
        send(35, 0, 1);
        send(1, 1, 0);
        send(65535, 65535, 1);
        send(65535, 1, 1);
        send(40960, 12288, 1);
        wait_idle();

        // Backpressure: result must hold, busy in_valid must be ignored
        or_man = 1'b0;
        send(48, 18, 1);
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 100) begin cyc++; @(negedge clk); end
        check("bp_out_valid_seen", out_valid, 1);
        @(posedge clk); #1;
        in_valid = 1'b1; a_in = 16'd100; b_in = 16'd10; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_gcd_out", gcd_out, 6);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        or_man   = 1'b1;
        wait_idle();
        repeat (5) @(negedge clk);

        // Reset in the middle of a subtractive run
        send(143, 78, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        repeat (12) @(negedge clk);
        check("midrst_no_output", out_valid, 0);
        send(12, 8, 0);
        wait_idle();

        // Randomised traffic with random output backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rm = 1'($urandom_range(0, 1));
            if (rm) begin
                ra = $urandom & 32'hFFFF;
                rb = $urandom & 32'hFFFF;
            end else begin
                ra = $urandom_range(0, 511);
                rb = $urandom_range(0, 511);
            end
            if ($urandom_range(0, 9) == 0) ra = 0;
            if ($urandom_range(0, 9) == 0) rb = ra;
            send(ra, rb, rm);
        end
        rand_mode = 1'b0;
        wait_idle();

        // 8-bit instance: worst-case subtractive run and the binary equivalent
        for (int m = 0; m < 2; m++) begin
            e8 = make_exp(255, 1, 1'(m), 8);
            @(posedge clk); #1;
            in_valid8 = 1'b1; a_in8 = 8'd255; b_in8 = 8'd1; mode8 = 1'(m);
            @(negedge clk);
            check("w8_in_ready", in_ready8, 1);
            @(posedge clk); #1;
            in_valid8 = 1'b0; a_in8 = 8'd0; mode8 = ~mode8;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!out_valid8 && cyc < 1000);
            check("w8_gcd_out", gcd_out8, e8.gcd);
            check("w8_iter_cnt", iter_cnt8, e8.iter);
            check("w8_zero_in", zero_in8, 0);
            check("w8_latency", cyc, e8.lat);
            if (m == 1) check("w8_bin_iter_lt20", iter_cnt8 < 8'd20, 1);
            @(negedge clk);
            check("w8_out_valid_dropped", out_valid8, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised GCD unit; successor to the fixed 16-bit, serially-loaded subtractive GCD datapath/controller pair.
- Operands load in parallel through a valid/ready handshake. The result returns through a second valid/ready handshake.
- Run-time mode select: subtractive (Euclid) or binary (Stein) reduction.
- Reports the iteration count and a zero-operand flag. Sits as a compute slave behind a host/sequencer.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- ITER_W, WIDTH, iteration counter width; counter saturates at all-ones.
- SHIFT_W, $clog2(WIDTH)+1, width of the common-power-of-two counter k (binary mode).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand handshake valid.
- in_ready  out  1  high only in IDLE.
- a_in  in  WIDTH  operand A, unsigned.
- b_in  in  WIDTH  operand B, unsigned.
- mode  in  1  0 = subtractive, 1 = binary; sampled at accept.
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  result handshake ready.
- gcd_out  out  WIDTH  result.
- iter_cnt  out  ITER_W  reduction cycles used.
- zero_in  out  1  an operand was 0 at accept.

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-high. Clock port clk, reset port rst.
- Reset: state=IDLE, in_ready=1, out_valid=0, gcd_out=0, iter_cnt=0, zero_in=0, k=0. Reset mid-operation aborts the computation; the result is discarded and nothing is emitted.
- States: IDLE, SUB, BIN, SHIFT, DONE.
- IDLE, accept (in_valid && in_ready):
  - Register A, B and mode; clear iter_cnt and k.
  - If a_in==0 or b_in==0: gcd_out=a_in|b_in, zero_in=1, go to DONE (gcd(0,0)=0).
  - Otherwise go to SUB (mode 0) or BIN (mode 1).
- SUB, one step per cycle:
  - A==B: gcd_out=A, go to DONE.
  - A>B: A<=A-B. Otherwise B<=B-A. iter_cnt++ on each subtract.
- BIN, one step per cycle, first matching rule:
  - A==B: go to SHIFT.
  - Both even: A>>=1, B>>=1, k++.
  - A even: A>>=1.
  - B even: B>>=1.
  - A>B: A<=(A-B)>>1. Otherwise B<=(B-A)>>1.
  - iter_cnt++ on every non-terminal step.
- SHIFT: gcd_out=A<<k (single-cycle barrel shift), go to DONE.
- DONE: out_valid=1; gcd_out, iter_cnt and zero_in stable. On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: subtractive = iter_cnt+2 cycles from accept edge to out_valid. Binary = iter_cnt+3. Zero operand = 1.
- in_ready=0 outside IDLE. in_valid during busy is ignored and never queued.
- No back-to-back overlap: new accept is possible one cycle after the output handshake.
- Arithmetic: all unsigned, WIDTH bits. Subtracts never underflow (guarded by compare). iter_cnt saturates at 2^ITER_W-1 and does not wrap. k never exceeds WIDTH-1.
- mode and operand changes after accept have no effect.

Decomposition:
- Package gcd_pkg: state enum (IDLE, SUB, BIN, SHIFT, DONE), mode constants MODE_SUB=0 and MODE_BIN=1.
- One sub-module, gcd_step: purely combinational single-iteration datapath. Takes A, B, mode; returns next A, next B, k_inc, equal. The FSM, handshake and counters stay in gcd_engine.

Test Plan:
- Subtractive, WIDTH=16: A=143, B=78, mode=0 -> gcd_out=13, iter_cnt=6, zero_in=0; out_valid 8 cycles after accept.
- Binary: A=48, B=18, mode=1 -> gcd_out=6, iter_cnt=5, k=1 internally; out_valid 8 cycles after accept.
- Zero operands: (0,35) -> 35, zero_in=1, iter_cnt=0, out_valid 1 cycle after accept. (0,0) -> 0, zero_in=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> gcd_out and out_valid stable, in_ready=0. Pulse in_valid with new data meanwhile -> ignored.
- Reset mid-op: assert rst during SUB of (143,78) -> next cycle in_ready=1, out_valid=0. Then (12,8) -> 4, iter_cnt=2.
- WIDTH=8 instance: (255,1) mode 0 -> gcd_out=1, iter_cnt=254. Same in mode 1 -> gcd_out=1, fewer than 20 iterations.
